flick_master_gen: RTL and testbench



---
 rtl/flick_master_gen.sv | 157 +++++++++++++++
 tb/tb_flick_master_gen.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flick_master_gen.sv
// Flick game round sequencer: free-running LFSR arrows, answer judging, score/streak, lockout and game timer.
// Optional build macro FLICK_STREAK_BONUS_EN scales the per-answer score increment with the current streak.
module flick_master_gen #(
    parameter logic [2:0] GAME_ID    = 3'd0,
    parameter int         GAME_TICKS = 3000,
    parameter int         LOCK_TICKS = 50,
    parameter int         SCORE_W    = 10,
    parameter int         STREAK_W   = 6,
    parameter logic [7:0] LFSR_SEED  = 8'hA5,
    parameter logic [3:0] KEY_UP     = 4'd2,
    parameter logic [3:0] KEY_DOWN   = 4'd8,
    parameter logic [3:0] KEY_LEFT   = 4'd4,
    parameter logic [3:0] KEY_RIGHT  = 4'd6
) (
    input  logic                clk_100,
    input  logic                rst,
    input  logic [2:0]          game_en,
    input  logic                start,
    input  logic [3:0]          key,
    input  logic                pressed,
    output logic [1:0]          arrow_dir,
    output logic                arrow_inv,
    output logic                arrow_vld,
    output logic                point,
    output logic                miss,
    output logic [SCORE_W-1:0]  score,
    output logic [STREAK_W-1:0] streak,
    output logic [11:0]         time_left,
    output logic                game_over
);
    typedef enum logic [1:0] {IDLE, SHOW, LOCK, DONE} state_t;

    state_t             state, state_nxt;
    logic [7:0]         lfsr;
    logic [11:0]        lock_cnt;
    logic               enabled, key_hit, judge, correct, wrong;
    logic               time_up, lock_done, start_go, draw;
    logic [1:0]         key_dir, want_dir;
    logic [SCORE_W-1:0] score_inc;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

    assign enabled = (game_en == GAME_ID);

    always_comb begin
        key_hit = 1'b1;
        key_dir = 2'd0;
        if (key == KEY_UP)         key_dir = 2'd0;
        else if (key == KEY_DOWN)  key_dir = 2'd1;
        else if (key == KEY_RIGHT) key_dir = 2'd2;
        else if (key == KEY_LEFT)  key_dir = 2'd3;
        else                       key_hit = 1'b0;
    end

    // Inversion swaps within an axis: up<->down (0/1), right<->left (2/3).
    assign want_dir  = arrow_dir ^ {1'b0, arrow_inv};
    assign judge     = enabled && (state == SHOW) && pressed && !start && key_hit;
    assign correct   = judge && (key_dir == want_dir);
    assign wrong     = judge && (key_dir != want_dir);
    assign time_up   = ((state == SHOW) || (state == LOCK)) && (time_left == 12'd1);
    assign lock_done = (state == LOCK) && (lock_cnt <= 12'd1);
    assign start_go  = enabled && start && ((state == IDLE) || (state == DONE));
    assign draw      = start_go || correct || (enabled && lock_done && !time_up);

    always_comb begin
`ifdef FLICK_STREAK_BONUS_EN
        if ((streak >> 3) >= STREAK_W'(3)) score_inc = SCORE_W'(4);
        else                               score_inc = SCORE_W'(streak >> 3) + SCORE_W'(1);
`else
        score_inc = SCORE_W'(1);
`endif
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enabled) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_nxt = SHOW;
                SHOW: begin
                    if (time_up)    state_nxt = DONE;
                    else if (wrong) state_nxt = LOCK;
                end
                LOCK: begin
                    if (time_up)        state_nxt = DONE;
                    else if (lock_done) state_nxt = SHOW;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        arrow_vld = (state == SHOW);
        game_over = (state == DONE);
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            lfsr      <= LFSR_SEED;
            arrow_dir <= 2'd0;
            arrow_inv <= 1'b0;
            point     <= 1'b0;
            miss      <= 1'b0;
            score     <= '0;
            streak    <= '0;
            time_left <= 12'd0;
            lock_cnt  <= 12'd0;
        end else begin
            lfsr  <= lfsr_step(lfsr);
            point <= correct;
            miss  <= wrong;
            if (draw) begin
                arrow_dir <= lfsr[1:0];
                arrow_inv <= lfsr[2];
            end
            if (!enabled) begin
                time_left <= 12'd0;
            end else if (start_go) begin
                time_left <= 12'(GAME_TICKS);
                score     <= '0;
                streak    <= '0;
            end else begin
                if ((state == SHOW) || (state == LOCK)) time_left <= time_left - 12'd1;
                if (correct) begin
                    score  <= sat_add(score, score_inc);
                    streak <= sat_inc(streak);
                end
                if (wrong) begin
                    streak   <= '0;
                    lock_cnt <= 12'(LOCK_TICKS);
                end else if ((state == LOCK) && (lock_cnt != 12'd0)) begin
                    lock_cnt <= lock_cnt - 12'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_flick_master_gen.sv
// Randomised bench for flick_master_gen against a game-rule model (LFSR sequence, score/streak arithmetic).
// A second instance with a 20-tick game covers the timer expiry.
module tb_flick_master_gen;
    localparam int GT       = 3000;
    localparam int SHORT_GT = 20;
`ifdef FLICK_STREAK_BONUS_EN
    localparam int TEN_SCORE = 12;
`else
    localparam int TEN_SCORE = 10;
`endif

    logic       clk_100 = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] game_en = 3'd1;
    logic       start = 1'b0;
    logic [3:0] key = 4'd0;
    logic       pressed = 1'b0;

    logic [1:0]  arrow_dir, s_arrow_dir;
    logic        arrow_inv, arrow_vld, point, miss, game_over;
    logic        s_arrow_inv, s_arrow_vld, s_point, s_miss, s_game_over;
    logic [9:0]  score, s_score;
    logic [5:0]  streak, s_streak;
    logic [11:0] time_left, s_time_left;

    flick_master_gen dut (
        .clk_100(clk_100), .rst(rst), .game_en(game_en), .start(start), .key(key), .pressed(pressed),
        .arrow_dir(arrow_dir), .arrow_inv(arrow_inv), .arrow_vld(arrow_vld), .point(point), .miss(miss),
        .score(score), .streak(streak), .time_left(time_left), .game_over(game_over)
    );

    flick_master_gen #(.GAME_TICKS(SHORT_GT)) dut_short (
        .clk_100(clk_100), .rst(rst), .game_en(game_en), .start(start), .key(key), .pressed(pressed),
        .arrow_dir(s_arrow_dir), .arrow_inv(s_arrow_inv), .arrow_vld(s_arrow_vld), .point(s_point),
        .miss(s_miss), .score(s_score), .streak(s_streak), .time_left(s_time_left), .game_over(s_game_over)
    );

    always #5 clk_100 = ~clk_100;

    int checks, passed;
    int edges, start_edge;
    logic [7:0] m_lfsr;
    logic [1:0] e_dir;
    logic       e_inv;
    int         e_score, e_streak;

    // Reference LFSR: polynomial x^8+x^6+x^5+x^4+1, taps as a mask
    always @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            m_lfsr <= 8'hA5;
            edges  <= 0;
        end else begin
            m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            edges  <= edges + 1;
        end
    end

    task automatic tick();
        @(negedge clk_100);
    endtask

    function automatic logic [3:0] dir_key(input logic [1:0] d);
        case (d)
            2'd0:    return 4'd2;
            2'd1:    return 4'd8;
            2'd2:    return 4'd6;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] answer_key(input logic [1:0] d, input logic inv);
        logic [1:0] a;
        a = d;
        if (inv) begin
            case (d)
                2'd0:    a = 2'd1;
                2'd1:    a = 2'd0;
                2'd2:    a = 2'd3;
                default: a = 2'd2;
            endcase
        end
        return dir_key(a);
    endfunction

    task automatic model_correct();
        int inc;
`ifdef FLICK_STREAK_BONUS_EN
        inc = 1 + ((e_streak / 8 > 3) ? 3 : e_streak / 8);
`else
        inc = 1;
`endif
        e_score  = (e_score + inc > 1023) ? 1023 : e_score + inc;
        e_streak = (e_streak == 63) ? 63 : e_streak + 1;
    endtask

    task automatic press_correct();
        key     = answer_key(e_dir, e_inv);
        pressed = 1'b1;
        e_dir   = m_lfsr[1:0];
        e_inv   = m_lfsr[2];
        model_correct();
        tick();
        pressed = 1'b0;
    endtask

    task automatic begin_game();
        game_en    = 3'd0;
        start      = 1'b1;
        e_dir      = m_lfsr[1:0];
        e_inv      = m_lfsr[2];
        e_score    = 0;
        e_streak   = 0;
        start_edge = edges + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({arrow_dir, arrow_inv, arrow_vld, point, miss} !== 6'd0)
            $display("FAIL reset_flags: got dir=%0d inv=%0b vld=%0b point=%0b miss=%0b, want all 0",
                     arrow_dir, arrow_inv, arrow_vld, point, miss);
        else passed++;
        checks++;
        if (score !== 10'd0 || streak !== 6'd0) $display("FAIL reset_score: got %0d/%0d, want 0/0", score, streak);
        else passed++;
        checks++;
        if (time_left !== 12'd0 || game_over !== 1'b0)
            $display("FAIL reset_timer: got time_left=%0d game_over=%0b, want 0/0", time_left, game_over);
        else passed++;
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (arrow_vld !== 1'b0 || time_left !== 12'd0 || game_over !== 1'b0)
            $display("FAIL disabled_start: got vld=%0b time_left=%0d over=%0b, want 0/0/0", arrow_vld, time_left, game_over);
        else passed++;
    endtask

    task automatic test_first_draw();
        begin_game();
        checks++;
        if (arrow_vld !== 1'b1) $display("FAIL first_vld: got %0b, want 1", arrow_vld);
        else passed++;
        checks++;
        if (arrow_dir !== e_dir || arrow_inv !== e_inv)
            $display("FAIL first_arrow: got dir=%0d inv=%0b, want dir=%0d inv=%0b", arrow_dir, arrow_inv, e_dir, e_inv);
        else passed++;
        checks++;
        if (time_left !== 12'(GT)) $display("FAIL first_time: got %0d, want %0d", time_left, GT);
        else passed++;
        checks++;
        if (score !== 10'd0 || streak !== 6'd0 || point !== 1'b0)
            $display("FAIL first_score: got score=%0d streak=%0d point=%0b, want 0/0/0", score, streak, point);
        else passed++;
    endtask

    task automatic test_correct();
        int npts, nmiss;
        npts = 0;
        nmiss = 0;
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                if (point) npts++;
                if (miss) nmiss++;
            end
            press_correct();
            if (point) npts++;
            if (miss) nmiss++;
            checks++;
            if (arrow_dir !== e_dir || arrow_inv !== e_inv)
                $display("FAIL correct_arrow[%0d]: got dir=%0d inv=%0b, want dir=%0d inv=%0b", i, arrow_dir, arrow_inv, e_dir, e_inv);
            else passed++;
        end
        checks++;
        if (npts != 5 || nmiss != 0) $display("FAIL correct_pulses: got points=%0d misses=%0d, want 5/0", npts, nmiss);
        else passed++;
        checks++;
        if (score !== 10'd5 || streak !== 6'd5) $display("FAIL correct_score: got %0d/%0d, want 5/5", score, streak);
        else passed++;
    endtask

    task automatic test_bonus();
        for (int i = 0; i < 5; i++) press_correct();
        checks++;
        if (score !== 10'(TEN_SCORE) || score !== 10'(e_score))
            $display("FAIL ten_score: got %0d, want %0d", score, TEN_SCORE);
        else passed++;
        checks++;
        if (streak !== 6'd10) $display("FAIL ten_streak: got %0d, want 10", streak);
        else passed++;
    endtask

    task automatic test_random();
        int op;
        logic exp_pt;
        logic [3:0] k;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            exp_pt = 1'b0;
            if (op == 0) begin
                press_correct();
                exp_pt = 1'b1;
            end else if (op == 1) begin
                k = 4'($urandom_range(0, 15));
                while (k == 4'd2 || k == 4'd4 || k == 4'd6 || k == 4'd8) k = 4'($urandom_range(0, 15));
                key = k;
                pressed = 1'b1;
                tick();
                pressed = 1'b0;
            end else if (op == 2) begin
                key = answer_key(e_dir, e_inv);
                pressed = 1'b1;
                start = 1'b1;
                tick();
                pressed = 1'b0;
                start = 1'b0;
            end else begin
                tick();
            end
            checks++;
            if (point !== exp_pt || miss !== 1'b0 || arrow_dir !== e_dir || arrow_inv !== e_inv ||
                score !== 10'(e_score) || streak !== 6'(e_streak))
                $display("FAIL random[%0d] op=%0d: got point=%0b miss=%0b dir=%0d inv=%0b score=%0d streak=%0d, want point=%0b miss=0 dir=%0d inv=%0b score=%0d streak=%0d",
                         i, op, point, miss, arrow_dir, arrow_inv, score, streak, exp_pt, e_dir, e_inv, e_score, e_streak);
            else passed++;
        end
    endtask

    task automatic test_lock();
        int low, bad;
        logic saw_exit;
        logic [7:0] saved;
        key = answer_key(e_dir ^ 2'd2, e_inv);
        pressed = 1'b1;
        tick();
        pressed = 1'b0;
        e_streak = 0;
        checks++;
        if (miss !== 1'b1 || point !== 1'b0) $display("FAIL wrong_pulse: got miss=%0b point=%0b, want 1/0", miss, point);
        else passed++;
        checks++;
        if (streak !== 6'd0 || score !== 10'(e_score))
            $display("FAIL wrong_score: got streak=%0d score=%0d, want 0/%0d", streak, score, e_score);
        else passed++;
        low = arrow_vld ? 0 : 1;
        bad = 0;
        saw_exit = 1'b0;
        saved = 8'd0;
        for (int i = 1; i <= 60; i++) begin
            saved = m_lfsr;
            key = 4'($urandom_range(0, 15));
            pressed = 1'($urandom_range(0, 1));
            tick();
            pressed = 1'b0;
            if (point || miss) bad++;
            if (arrow_vld) begin
                saw_exit = 1'b1;
                break;
            end
            low++;
        end
        checks++;
        if (!saw_exit || low != 50) $display("FAIL lock_len: got %0d low cycles (exit=%0b), want 50", low, saw_exit);
        else passed++;
        checks++;
        if (bad != 0 || score !== 10'(e_score) || streak !== 6'd0)
            $display("FAIL lock_ignore: got %0d pulses score=%0d streak=%0d, want 0/%0d/0", bad, score, streak, e_score);
        else passed++;
        e_dir = saved[1:0];
        e_inv = saved[2];
        checks++;
        if (arrow_dir !== e_dir || arrow_inv !== e_inv)
            $display("FAIL lock_redraw: got dir=%0d inv=%0b, want dir=%0d inv=%0b", arrow_dir, arrow_inv, e_dir, e_inv);
        else passed++;
        checks++;
        if (int'(time_left) != GT - (edges - start_edge))
            $display("FAIL lock_time: got %0d, want %0d", time_left, GT - (edges - start_edge));
        else passed++;
    endtask

    task automatic test_disable();
        key = answer_key(e_dir, e_inv);
        pressed = 1'b1;
        game_en = 3'd1;
        tick();
        pressed = 1'b0;
        checks++;
        if (point !== 1'b0 || miss !== 1'b0 || arrow_vld !== 1'b0 || time_left !== 12'd0 || game_over !== 1'b0)
            $display("FAIL disable_clear: got point=%0b miss=%0b vld=%0b time=%0d over=%0b, want all 0",
                     point, miss, arrow_vld, time_left, game_over);
        else passed++;
        checks++;
        if (score !== 10'(e_score) || streak !== 6'(e_streak))
            $display("FAIL disable_keep: got %0d/%0d, want %0d/%0d", score, streak, e_score, e_streak);
        else passed++;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (arrow_vld !== 1'b0) $display("FAIL disable_start: got vld=%0b, want 0", arrow_vld);
        else passed++;
        begin_game();
        checks++;
        if (time_left !== 12'(GT) || score !== 10'd0 || streak !== 6'd0 || arrow_vld !== 1'b1)
            $display("FAIL restart: got time=%0d score=%0d streak=%0d vld=%0b, want %0d/0/0/1", time_left, score, streak, arrow_vld, GT);
        else passed++;
        checks++;
        if (arrow_dir !== e_dir || arrow_inv !== e_inv)
            $display("FAIL restart_arrow: got dir=%0d inv=%0b, want dir=%0d inv=%0b", arrow_dir, arrow_inv, e_dir, e_inv);
        else passed++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 1030; i++) press_correct();
        checks++;
        if (score !== 10'd1023 || e_score != 1023) $display("FAIL score_sat: got %0d, want 1023", score);
        else passed++;
        checks++;
        if (streak !== 6'd63 || point !== 1'b1) $display("FAIL streak_sat: got streak=%0d point=%0b, want 63/1", streak, point);
        else passed++;
    endtask

    task automatic test_timeout();
        int over_at, pulse_bad, arrow_bad;
        logic exp_pt;
        over_at = -1;
        pulse_bad = 0;
        arrow_bad = 0;
        game_en = 3'd1;
        tick();
        begin_game();
        for (int k = 1; k <= SHORT_GT; k++) begin
            if (s_arrow_dir !== e_dir || s_arrow_inv !== e_inv || s_arrow_vld !== 1'b1) arrow_bad++;
            exp_pt = 1'b0;
            if (k == 1 || k == 2 || k == SHORT_GT) begin
                key = answer_key(e_dir, e_inv);
                pressed = 1'b1;
                e_dir = m_lfsr[1:0];
                e_inv = m_lfsr[2];
                model_correct();
                exp_pt = 1'b1;
            end else if (k == 10) begin
                key = 4'd5;
                pressed = 1'b1;
            end
            tick();
            pressed = 1'b0;
            if (s_point !== exp_pt || s_miss !== 1'b0) pulse_bad++;
            if (s_game_over === 1'b1 && over_at < 0) over_at = k;
        end
        checks++;
        if (over_at != SHORT_GT) $display("FAIL timeout_edge: got game_over at cycle %0d, want %0d", over_at, SHORT_GT);
        else passed++;
        checks++;
        if (s_time_left !== 12'd0 || s_arrow_vld !== 1'b0)
            $display("FAIL timeout_state: got time=%0d vld=%0b, want 0/0", s_time_left, s_arrow_vld);
        else passed++;
        checks++;
        if (pulse_bad != 0 || arrow_bad != 0)
            $display("FAIL timeout_play: got %0d pulse errors %0d arrow errors, want 0/0", pulse_bad, arrow_bad);
        else passed++;
        checks++;
        if (s_score !== 10'd3 || s_streak !== 6'd3) $display("FAIL timeout_score: got %0d/%0d, want 3/3", s_score, s_streak);
        else passed++;
        press_correct();
        checks++;
        if (s_point !== 1'b0 || s_score !== 10'd3 || s_game_over !== 1'b1)
            $display("FAIL done_frozen: got point=%0b score=%0d over=%0b, want 0/3/1", s_point, s_score, s_game_over);
        else passed++;
        checks++;
        if (score !== 10'(e_score) || point !== 1'b1) $display("FAIL main_after_timeout: got %0d, want %0d", score, e_score);
        else passed++;
    endtask

    task automatic test_reset_mid_lock();
        key = answer_key(e_dir ^ 2'd2, e_inv);
        pressed = 1'b1;
        tick();
        pressed = 1'b0;
        repeat (5) tick();
        checks++;
        if (arrow_vld !== 1'b0 || score === 10'd0) $display("FAIL pre_reset_lock: got vld=%0b score=%0d, want 0/nonzero", arrow_vld, score);
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({arrow_dir, arrow_inv, arrow_vld, point, miss, game_over} !== 7'd0 ||
            score !== 10'd0 || streak !== 6'd0 || time_left !== 12'd0)
            $display("FAIL async_reset: got dir=%0d inv=%0b vld=%0b point=%0b miss=%0b over=%0b score=%0d streak=%0d time=%0d, want all 0",
                     arrow_dir, arrow_inv, arrow_vld, point, miss, game_over, score, streak, time_left);
        else passed++;
        tick();
        rst = 1'b0;
        begin_game();
        checks++;
        if (arrow_dir !== 2'd1 || arrow_inv !== 1'b1 || arrow_vld !== 1'b1)
            $display("FAIL reseed_draw: got dir=%0d inv=%0b vld=%0b, want 1/1/1", arrow_dir, arrow_inv, arrow_vld);
        else passed++;
        checks++;
        if (time_left !== 12'(GT)) $display("FAIL reseed_time: got %0d, want %0d", time_left, GT);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_first_draw();
        test_correct();
        test_bonus();
        test_random();
        test_lock();
        test_disable();
        test_saturation();
        test_timeout();
        test_reset_mid_lock();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
